// File: rtl/inter_switch_sched.sv
// Route scheduler for inter_switch: accepts route commands, drives ctrl and counts the
// accepted beats per command. The input side is parked around every reconfiguration.
module inter_switch_sched #(
    parameter logic [2:0]  PARK_SRC   = 3'd7,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    input  logic [4:0]  in_fire,
    input  logic [7:0]  out_fire,
    input  logic        abort,
    output logic [17:0] ctrl,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {StIdle, StSettle, StRun, StDrain, StFin} state_e;

    localparam logic [2:0] SettleLast = 3'(SETTLE_CYC - 1);

    state_e      state_q;
    logic [2:0]  src_q, dst_q, settle_q;
    logic [15:0] in_beats_q, in_cnt_q;
    logic [19:0] out_beats_q, out_cnt_q, out_cnt_nx;
    logic [17:0] ctrl_q;
    logic        tready_q, busy_q, done_q, err_q;

    logic [7:0]  in_fire_ext;
    logic        in_hit, out_hit, out_full, in_last, out_last, parked, stray_out;
    logic        err_set, cmd_hs, cmd_bad, abort_hit;
    logic        unused_rsvd;

    assign unused_rsvd = ^s_cmd_tdata[63:54];

    always_comb begin
        in_fire_ext = {3'b000, in_fire};
        in_hit      = in_fire_ext[src_q];
        out_hit     = out_fire[dst_q];
        stray_out   = |(out_fire & ~(8'd1 << dst_q));
        parked      = ctrl_q[2:0] == PARK_SRC;
        out_full    = out_cnt_q == out_beats_q;
        // out_cnt saturates at out_beats; the extra beat is flagged through err instead
        out_cnt_nx  = out_cnt_q + 20'(out_hit && !out_full);
        in_last     = in_hit && (in_cnt_q + 16'd1 == in_beats_q);
        out_last    = out_hit && !out_full && (out_cnt_nx == out_beats_q);
        err_set     = ((state_q == StRun || state_q == StDrain) &&
                       (stray_out || (out_hit && out_full))) ||
                      (state_q != StIdle && parked && in_hit);
        cmd_hs      = tready_q && s_cmd_tvalid;
        cmd_bad     = s_cmd_tdata[2:0] > 3'd4;
        abort_hit   = abort && (state_q == StSettle || state_q == StRun || state_q == StDrain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            src_q       <= 3'd0;
            dst_q       <= 3'd0;
            settle_q    <= 3'd0;
            in_beats_q  <= 16'd0;
            in_cnt_q    <= 16'd0;
            out_beats_q <= 20'd0;
            out_cnt_q   <= 20'd0;
            ctrl_q      <= {15'd0, PARK_SRC};
            tready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            if (abort_hit) begin
                ctrl_q[2:0] <= PARK_SRC;
                in_cnt_q    <= 16'd0;
                out_cnt_q   <= 20'd0;
                done_q      <= 1'b1;
                state_q     <= StFin;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tready_q <= 1'b1;
                        if (cmd_hs && cmd_bad) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (cmd_hs) begin
                            ctrl_q      <= {s_cmd_tdata[17:3], PARK_SRC};
                            src_q       <= s_cmd_tdata[2:0];
                            dst_q       <= s_cmd_tdata[5:3];
                            in_beats_q  <= s_cmd_tdata[33:18];
                            out_beats_q <= s_cmd_tdata[53:34];
                            in_cnt_q    <= 16'd0;
                            out_cnt_q   <= 20'd0;
                            settle_q    <= 3'd0;
                            tready_q    <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= StSettle;
                        end
                    end
                    StSettle: begin
                        if (settle_q == SettleLast) begin
                            if (in_beats_q == 16'd0) begin
                                state_q <= StDrain;
                            end else begin
                                ctrl_q[2:0] <= src_q;
                                state_q     <= StRun;
                            end
                        end else begin
                            settle_q <= settle_q + 3'd1;
                        end
                    end
                    StRun: begin
                        in_cnt_q  <= in_cnt_q + 16'(in_hit);
                        out_cnt_q <= out_cnt_nx;
                        // park on the edge that takes the last input beat
                        if (in_last) begin
                            ctrl_q[2:0] <= PARK_SRC;
                            if (out_last) begin
                                done_q  <= 1'b1;
                                state_q <= StFin;
                            end else begin
                                state_q <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        out_cnt_q <= out_cnt_nx;
                        if (out_cnt_nx == out_beats_q) begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                    StFin: begin
                        tready_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign s_cmd_tready = tready_q;
    assign ctrl         = ctrl_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_inter_switch_sched.sv
// Scoreboard bench for inter_switch_sched: the driver predicts when each command finishes
// and what ctrl/err look like then; a negedge monitor checks every done pulse against that.
module tb_inter_switch_sched;
    localparam int         SETTLE = 2;
    localparam logic [2:0] PARK   = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_cmd_tdata = '0;
    logic        s_cmd_tvalid = 1'b0;
    logic        s_cmd_tready;
    logic [4:0]  in_fire = '0;
    logic [7:0]  out_fire = '0;
    logic        abort = 1'b0;
    logic [17:0] ctrl;
    logic        busy, done, err;

    inter_switch_sched #(.PARK_SRC(PARK), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid),
        .s_cmd_tready(s_cmd_tready), .in_fire(in_fire), .out_fire(out_fire), .abort(abort),
        .ctrl(ctrl), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [17:0] ctrl;
        logic        err;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        err_exp = 1'b0;
    logic [17:0] ctrl_exp = {15'd0, 3'd7};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int t, input logic [17:0] c, input logic er, input logic b);
        exp_t e;
        e.t = t; e.ctrl = c; e.err = er; e.busy = b;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                got_e = exp_q.pop_front();
                chk("done_cycle", cyc, got_e.t);
                chk("done_ctrl", 32'(ctrl), 32'(got_e.ctrl));
                chk("done_err", 32'(err), 32'(got_e.err));
                chk("done_busy", 32'(busy), 32'(got_e.busy));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 60) begin
            step();
            g++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done want done at cycle %0d", exp_q[0].t);
            exp_q.delete();
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tready", 32'(s_cmd_tready), 32'd1);
    endtask

    task automatic run_cmd(input logic [2:0] src, input logic [2:0] dst, input logic [2:0] sc,
                           input logic [8:0] sr, input int inb, input int outb, input int pct,
                           input bit do_abort, input bit do_stray);
        logic [63:0] d;
        int e0, e2, in_sent, out_sent, in_done, last_out, guard, t, sidx;
        bit run, drain, strayed;
        d = '0;
        d[2:0] = src; d[5:3] = dst; d[8:6] = sc; d[17:9] = sr;
        d[33:18] = 16'(inb); d[53:34] = 20'(outb); d[63:54] = 10'($urandom);
        s_cmd_tdata = d;
        s_cmd_tvalid = 1'b1;
        guard = 0;
        while (!s_cmd_tready && guard < 20) begin
            step();
            guard++;
        end
        if (!s_cmd_tready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_accept: got tready=0 want 1");
            s_cmd_tvalid = 1'b0;
            return;
        end
        e0 = cyc + 1;
        if (src > 3'd4) begin
            err_exp = 1'b1;
            push_exp(e0, ctrl_exp, 1'b1, 1'b0);
            step();
            s_cmd_tvalid = 1'b0;
            wait_done();
            return;
        end
        ctrl_exp = {sr, sc, dst, PARK};
        step();
        s_cmd_tvalid = 1'b0;
        e2 = e0 + SETTLE;
        in_sent = 0; out_sent = 0; last_out = -1; strayed = 0; guard = 0;
        in_done = (inb == 0) ? e2 : -1;
        while ((in_sent < inb || out_sent < outb || cyc <= e2) && guard < 400) begin
            in_fire = '0; out_fire = '0; abort = 1'b0;
            if (cyc == e2 - 1) chk("settle_parked", 32'(ctrl[2:0]), 32'(PARK));
            if (cyc == e2) chk("run_ctrl", 32'(ctrl), 32'({sr, sc, dst, (inb != 0) ? src : PARK}));
            if (in_done >= 0 && cyc == in_done && inb != 0)
                chk("park_after_last_in", 32'(ctrl[2:0]), 32'(PARK));
            run = (ctrl[2:0] == src);
            drain = (in_done >= 0 && cyc + 1 > in_done);
            if (do_abort && in_sent == 1 && run) begin
                abort = 1'b1;
                push_exp(cyc + 1, ctrl_exp, err_exp, 1'b1);
                step();
                abort = 1'b0;
                wait_done();
                return;
            end
            if (in_sent < inb && run && $urandom_range(99) < pct) begin
                in_fire = 5'd1 << src;
                in_sent++;
                if (in_sent == inb) in_done = cyc + 1;
            end
            if (out_sent < outb && (run || drain) && $urandom_range(99) < pct) begin
                out_fire = 8'd1 << dst;
                out_sent++;
                last_out = cyc + 1;
            end
            if (do_stray && !strayed && (run || drain)) begin
                sidx = (int'(dst) + 1 + int'($urandom_range(6))) % 8;
                out_fire = out_fire | (8'd1 << sidx);
                strayed = 1;
                err_exp = 1'b1;
            end
            step();
            guard++;
        end
        in_fire = '0; out_fire = '0;
        if (guard >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: got %0d/%0d beats want %0d/%0d", in_sent, out_sent, inb, outb);
        end
        t = (outb > 0 && last_out >= in_done) ? last_out : in_done + 1;
        push_exp(t, ctrl_exp, err_exp, 1'b1);
        wait_done();
    endtask

    initial begin
        int g;
        int inb;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'(ctrl), 32'({15'd0, PARK}));
        chk("rst_tready", 32'(s_cmd_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();

        run_cmd(3'd4, 3'd7, 3'd0, 9'h000, 3, 3, 100, 0, 0);
        run_cmd(3'd1, 3'd4, 3'd2, 9'h055, 2, 24, 100, 0, 0);
        run_cmd(3'd0, 3'd0, 3'd5, 9'h1A3, 0, 2, 100, 0, 0);
        run_cmd(3'd2, 3'd1, 3'd3, 9'h0F0, 4, 0, 100, 0, 0);
        run_cmd(3'd3, 3'd2, 3'd1, 9'h0F0, 4, 2, 100, 1, 0);
        run_cmd(3'd4, 3'd6, 3'd0, 9'h000, 0, 0, 100, 0, 0);
        chk("err_clean", 32'(err), 32'd0);
        run_cmd(3'd6, 3'd1, 3'd0, 9'h000, 1, 1, 100, 0, 0);
        run_cmd(3'd4, 3'd7, 3'd0, 9'h001, 2, 2, 100, 0, 1);

        for (int i = 0; i < 40; i++) begin
            inb = int'($urandom_range(5));
            run_cmd(($urandom_range(9) == 0) ? 3'(5 + $urandom_range(2)) : 3'($urandom_range(4)),
                    3'($urandom), 3'($urandom), 9'($urandom), inb, int'($urandom_range(6)),
                    int'($urandom_range(100, 40)), (inb >= 2) && ($urandom_range(5) == 0),
                    $urandom_range(7) == 0);
        end

        s_cmd_tdata = '0;
        s_cmd_tdata[2:0] = 3'd2; s_cmd_tdata[5:3] = 3'd3;
        s_cmd_tdata[33:18] = 16'd4; s_cmd_tdata[53:34] = 20'd4;
        s_cmd_tvalid = 1'b1;
        g = 0;
        while (!s_cmd_tready && g < 20) begin step(); g++; end
        step();
        s_cmd_tvalid = 1'b0;
        g = 0;
        while (ctrl[2:0] != 3'd2 && g < 10) begin step(); g++; end
        chk("mid_run_unpark", 32'(ctrl[2:0]), 32'd2);
        out_fire = 8'h20;
        step();
        out_fire = '0;
        chk("stray_err", 32'(err), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_src", 32'(ctrl[2:0]), 32'(PARK));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_err", 32'(err), 32'd0);
        exp_q.delete();
        err_exp = 1'b0;
        ctrl_exp = {15'd0, PARK};
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_cmd(3'd1, 3'd5, 3'd6, 9'h133, 2, 3, 70, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
